idex_operand_stage: RTL
=======================

// Module: idex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
//  Sits directly upstream of the ALU and drives its SrcA, SrcB and Operation inputs.
//  Captures decoded ID fields each cycle and inserts bubbles on load-use stall or flush.
//  Resolves RAW hazards from the EX/MEM and MEM/WB results.
// PARAMETERS
//  DATA_WIDTH     32  datapath width
//  REG_ADDR_W     5   register-file address width
//  OPCODE_LENGTH  4   ALU operation code width
// PORTS
//  clk              in   1           rising-edge clock (single domain)
//  reset            in   1           synchronous, active-low reset (0 = reset, sampled on clk)
//  id_valid         in   1           ID slot holds a real instruction
//  id_rs1_data      in   DATA_WIDTH  register-file read data, rs1
//  id_rs2_data      in   DATA_WIDTH  register-file read data, rs2
//  id_imm           in   DATA_WIDTH  sign-extended immediate
//  id_rs1, id_rs2   in   REG_ADDR_W  source register indices
//  id_rd            in   REG_ADDR_W  destination register index
//  id_alu_src       in   1           1 = SrcB takes the immediate
//  id_alu_op        in   OPCODE_LENGTH  ALU operation code
//  id_mem_read      in   1           instruction is a load
//  id_reg_write     in   1           instruction writes rd
//  flush            in   1           squash the ID instruction (branch taken)
//  exmem_reg_write  in   1           EX/MEM stage writes its rd
//  exmem_rd         in   REG_ADDR_W  EX/MEM destination register
//  exmem_result     in   DATA_WIDTH  EX/MEM ALU result
//  memwb_reg_write  in   1           MEM/WB stage writes its rd
//  memwb_rd         in   REG_ADDR_W  MEM/WB destination register
//  memwb_result     in   DATA_WIDTH  MEM/WB writeback value
//  load_use_stall   out  1           hold PC and IF/ID this cycle
//  ex_valid         out  1           EX slot holds a real instruction
//  SrcA, SrcB       out  DATA_WIDTH  ALU operands
//  Operation        out  OPCODE_LENGTH  ALU operation code
//  ex_store_data    out  DATA_WIDTH  forwarded rs2 value, for stores
//  ex_rd            out  REG_ADDR_W  destination register carried forward
//  ex_reg_write     out  1           reg-write control carried forward
//  ex_mem_read      out  1           load control carried forward
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - All ID/EX register fields clear to 0, so ex_valid=0 and Operation=4'b0000.
//   - Outputs SrcA/SrcB/ex_store_data = 0, load_use_stall=0.
//   - Reset overrides flush and stall. A reset mid-stall leaves no residue.
//  Latency: ID fields are captured at the clk edge and visible in EX one cycle later.
//   SrcA/SrcB are combinational from the registered fields plus the current forward inputs.
//  Capture priority per edge:
//   - reset, then flush, then load_use_stall, then normal load.
//   - flush or stall loads a bubble: valid=0, reg_write=0, mem_read=0, Operation=4'b0000, rd=0.
//  load_use_stall = ex_valid & ex_mem_read & id_valid & ~flush & (ex_rd!=0) &
//   (ex_rd==id_rs1 | (ex_rd==id_rs2 & ~id_alu_src)).
//   - It is combinational and asserted for exactly one cycle per hazard, because the next EX entry is a bubble.
//  Forwarding for rs1 (rs2 is identical):
//   - EX/MEM when exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1.
//   - Otherwise MEM/WB when memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs1.
//   - Otherwise the registered register-file data.
//   - When both stages match, EX/MEM wins. x0 is never forwarded.
//  SrcB = ex_alu_src ? ex_imm : forwarded rs2. ex_store_data is always forwarded rs2.
//  Widths: no arithmetic here; all data is passed at full DATA_WIDTH with no extension.
// STRUCTURE
//  Shared package pipeline_pkg holds:
//   - ALU op constants: ALU_AND=4'b0000, ALU_SUB=4'b0001, ALU_ADD=4'b0010, ALU_BNE=4'b0011,
//     ALU_OR=4'b0100, ALU_XOR=4'b0101, ALU_EQ=4'b1000.
//   - enum fwd_sel_e {FWD_REG, FWD_MEMWB, FWD_EXMEM}.
//   - packed struct idex_t (all registered fields).
//  Sub-module forwarding_unit (combinational) produces the rs1/rs2 fwd_sel_e selects.
//   It is instantiated once; the operand muxes and the register live in this module.
// TESTING
//  1. Reset: hold reset=0 for 2 clk edges with id_valid=1 -> ex_valid=0, Operation=0, SrcA=SrcB=0.
//  2. EX/MEM forward: ex_rs1=5, exmem_rd=5, exmem_result=32'h1234, memwb_rd=5,
//     memwb_result=32'hBEEF -> SrcA=32'h1234.
//  3. x0 guard: ex_rs2=0, exmem_rd=0, exmem_reg_write=1, exmem_result=7, ex_alu_src=0 -> SrcB=registered rs2 data.
//  4. Load-use: EX holds a load with rd=3, ID has rs1=3 -> load_use_stall=1 for 1 cycle.
//     Next cycle ex_valid=0 and load_use_stall=0.
//     With memwb_rd=3, memwb_result=32'hCAFE on the following cycle -> SrcA=32'hCAFE.
//  5. Flush and hazard together: flush=1 while the hazard is present -> load_use_stall=0, next ex_valid=0, ex_reg_write=0.
//  6. Immediate: id_alu_src=1, id_imm=-4, id_alu_op=ALU_ADD -> next cycle SrcB=32'hFFFFFFFC, Operation=4'b0010.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared ALU op codes, forwarding selects and the ID/EX register layout
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_BNE = 4'b0011;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_XOR = 4'b0101;
  localparam logic [OP_W-1:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  // All-zero value of this struct is the bubble / reset state
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              alu_src;
    logic [OP_W-1:0]   alu_op;
    logic              mem_read;
    logic              reg_write;
  } idex_t;

  // Youngest producer wins; x0 is hard-wired zero so it is never forwarded
  function automatic fwd_sel_e fwd_select(
    input logic [REG_W-1:0] src,
    input logic             exmem_we,
    input logic [REG_W-1:0] exmem_rd,
    input logic             memwb_we,
    input logic [REG_W-1:0] memwb_rd
  );
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
      return FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - combinational RAW forwarding select for both EX source operands
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W
) (
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  input  logic                  i_exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  output fwd_sel_e              o_fwd_a,
  output fwd_sel_e              o_fwd_b
);

  // Same priority rule applied independently to each operand
  always_comb begin
    o_fwd_a = fwd_select(i_ex_rs1, i_exmem_reg_write, i_exmem_rd,
                         i_memwb_reg_write, i_memwb_rd);
    o_fwd_b = fwd_select(i_ex_rs2, i_exmem_reg_write, i_exmem_rd,
                         i_memwb_reg_write, i_memwb_rd);
  end

endmodule

// File: rtl/idex_operand_stage.sv
// rtl/idex_operand_stage.sv - ID/EX register, operand forwarding muxes and load-use detection
module idex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int REG_ADDR_W    = REG_W,
  parameter int OPCODE_LENGTH = OP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_mem_read,
  input  logic                     id_reg_write,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     load_use_stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read
);

  // Register layout comes from the package, so the widths here track its constants
  idex_t                  r_idex;
  idex_t                  w_id_fields;
  fwd_sel_e               w_fwd_a;
  fwd_sel_e               w_fwd_b;
  logic [DATA_WIDTH-1:0]  w_rs1_fwd;
  logic [DATA_WIDTH-1:0]  w_rs2_fwd;
  logic                   w_stall;

  // Pack the decoded ID fields into the register format
  always_comb begin
    w_id_fields           = '0;
    w_id_fields.valid     = id_valid;
    w_id_fields.rs1_data  = id_rs1_data;
    w_id_fields.rs2_data  = id_rs2_data;
    w_id_fields.imm       = id_imm;
    w_id_fields.rs1       = id_rs1;
    w_id_fields.rs2       = id_rs2;
    w_id_fields.rd        = id_rd;
    w_id_fields.alu_src   = id_alu_src;
    w_id_fields.alu_op    = id_alu_op;
    w_id_fields.mem_read  = id_mem_read;
    w_id_fields.reg_write = id_reg_write;
  end

  // Load in EX whose rd is needed by ID; an immediate-form rs2 is not a real read
  always_comb begin
    w_stall = r_idex.valid & r_idex.mem_read & id_valid & ~flush &
              (r_idex.rd != '0) &
              ((r_idex.rd == id_rs1) | ((r_idex.rd == id_rs2) & ~id_alu_src));
  end

  // Reset, then flush/stall bubble (all-zero), then normal capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idex <= '0;
    end else if (flush || w_stall) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_id_fields;
    end
  end

  forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forwarding_unit (
    .i_ex_rs1          (r_idex.rs1),
    .i_ex_rs2          (r_idex.rs2),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .o_fwd_a           (w_fwd_a),
    .o_fwd_b           (w_fwd_b)
  );

  // Operand muxes: pick the youngest value of each source register
  always_comb begin
    w_rs1_fwd = r_idex.rs1_data;
    w_rs2_fwd = r_idex.rs2_data;
    case (w_fwd_a)
      FWD_EXMEM: w_rs1_fwd = exmem_result;
      FWD_MEMWB: w_rs1_fwd = memwb_result;
      default:   w_rs1_fwd = r_idex.rs1_data;
    endcase
    case (w_fwd_b)
      FWD_EXMEM: w_rs2_fwd = exmem_result;
      FWD_MEMWB: w_rs2_fwd = memwb_result;
      default:   w_rs2_fwd = r_idex.rs2_data;
    endcase
  end

  // Drive the ALU interface and the controls carried to EX/MEM
  always_comb begin
    load_use_stall = w_stall;
    ex_valid       = r_idex.valid;
    SrcA           = w_rs1_fwd;
    SrcB           = r_idex.alu_src ? r_idex.imm : w_rs2_fwd;
    Operation      = r_idex.alu_op;
    ex_store_data  = w_rs2_fwd;
    ex_rd          = r_idex.rd;
    ex_reg_write   = r_idex.reg_write;
    ex_mem_read    = r_idex.mem_read;
  end

endmodule
